// File: rtl/rob_pkg.sv
// Shared system definitions for the reorder buffer slice.
// Holds the superscalar width, the ROB depth, the width of the per-cycle
// lane counts, and the ROB_PACKET layout carried through dispatch and retire.
// Ports: none (package).
package rob_pkg;

    localparam int N               = 3;
    localparam int ROB_SZ          = 8;
    localparam int NUM_SCALAR_BITS = $clog2(N + 1);

    localparam int PREG_W = 6;
    localparam int AREG_W = 5;

    typedef struct packed {
        logic [PREG_W-1:0] t_new;
        logic [PREG_W-1:0] t_old;
        logic [AREG_W-1:0] arch_dest;
        logic [31:0]       pc;
        logic              halt;
        logic              illegal;
    } rob_packet_t;

endpackage

// File: rtl/rob_if.sv
// Dispatch/retire bus of the reorder buffer.
// master: pipeline side, drives flush, rob_inputs, num_dispatching and
//         num_retiring; observes rob_spots, rob_outputs, rob_outputs_valid.
// slave:  the ROB itself, the mirror image.
interface rob_if #(
    parameter int N = rob_pkg::N
);
    import rob_pkg::*;

    logic                       flush;
    rob_packet_t                rob_inputs [N];
    logic [NUM_SCALAR_BITS-1:0] num_dispatching;
    logic [NUM_SCALAR_BITS-1:0] rob_spots;
    rob_packet_t                rob_outputs [N];
    logic [NUM_SCALAR_BITS-1:0] rob_outputs_valid;
    logic [NUM_SCALAR_BITS-1:0] num_retiring;

    modport master (
        output flush,
        output rob_inputs,
        output num_dispatching,
        output num_retiring,
        input  rob_spots,
        input  rob_outputs,
        input  rob_outputs_valid
    );

    modport slave (
        input  flush,
        input  rob_inputs,
        input  num_dispatching,
        input  num_retiring,
        output rob_spots,
        output rob_outputs,
        output rob_outputs_valid
    );

endinterface

// File: rtl/rob_sva.sv
// Property checker for the reorder buffer occupancy bookkeeping.
// Ports: clock, reset, num_retiring, rob_outputs_valid, rob_spots, and the
// internal occupancy count. Over-retirement is only a warning because the
// ROB clamps the request to the valid head entries.
module rob_sva #(
    parameter int N        = 3,
    parameter int ROB_SZ   = 8,
    parameter int CNT_W    = 4,
    parameter int SCALAR_W = 2
) (
    input logic                clock,
    input logic                reset,
    input logic [SCALAR_W-1:0] num_retiring,
    input logic [SCALAR_W-1:0] rob_outputs_valid,
    input logic [SCALAR_W-1:0] rob_spots,
    input logic [CNT_W-1:0]    count
);

    count_bound: assert property (@(posedge clock) disable iff (reset)
        count <= CNT_W'(ROB_SZ))
        else $error("rob_sva: count above ROB_SZ");

    valid_le_count: assert property (@(posedge clock) disable iff (reset)
        (CNT_W'(rob_outputs_valid) <= count) && (int'(rob_outputs_valid) <= N))
        else $error("rob_sva: rob_outputs_valid exceeds count or N");

    spots_le_free: assert property (@(posedge clock) disable iff (reset)
        ((CNT_W + 1)'(rob_spots) + (CNT_W + 1)'(count)) <= (CNT_W + 1)'(ROB_SZ))
        else $error("rob_sva: rob_spots exceeds free entries");

    retire_le_valid: assert property (@(posedge clock) disable iff (reset)
        num_retiring <= rob_outputs_valid)
        else $warning("rob_sva: num_retiring above rob_outputs_valid, clamped");

endmodule

// File: rtl/rob.sv
// Reorder buffer: circular array of ROB_PACKET entries.
// Ports: clock, reset (synchronous, active-high), bus (rob_if.slave) carrying
// flush, dispatch lanes/count, retire count, free-spot count and the N oldest
// entries. Dispatch is clamped to the free space seen at the start of the
// cycle; retire is clamped to the valid head lanes. Flush and reset empty the
// buffer without clearing entry contents.
module rob #(
    parameter int N      = rob_pkg::N,
    parameter int ROB_SZ = rob_pkg::ROB_SZ
) (
    input logic   clock,
    input logic   reset,
    rob_if.slave  bus
);
    import rob_pkg::*;

    localparam int PTR_W = (ROB_SZ > 1) ? $clog2(ROB_SZ) : 1;
    localparam int CNT_W = $clog2(ROB_SZ + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    ptr_t        head_r;
    ptr_t        tail_r;
    cnt_t        count_r;
    rob_packet_t entries_r [ROB_SZ];

    cnt_t free_s;
    cnt_t spots_s;
    cnt_t valid_s;
    cnt_t disp_req_s;
    cnt_t ret_req_s;
    cnt_t disp_s;
    cnt_t ret_s;

    // Pointer plus offset modulo ROB_SZ; ptr < ROB_SZ and k <= ROB_SZ, so one
    // conditional subtraction covers every case, power of two or not.
    function automatic ptr_t ptr_add(input ptr_t ptr, input cnt_t k);
        logic [CNT_W:0] sum;
        logic [CNT_W:0] wrapped;
        sum     = (CNT_W + 1)'(ptr) + (CNT_W + 1)'(k);
        wrapped = (sum >= (CNT_W + 1)'(ROB_SZ)) ? (sum - (CNT_W + 1)'(ROB_SZ)) : sum;
        return wrapped[PTR_W-1:0];
    endfunction

    // Occupancy-derived offers and the clamped dispatch/retire amounts.
    always_comb begin
        free_s     = cnt_t'(ROB_SZ) - count_r;
        spots_s    = (free_s > cnt_t'(N)) ? cnt_t'(N) : free_s;
        valid_s    = (count_r > cnt_t'(N)) ? cnt_t'(N) : count_r;
        disp_req_s = cnt_t'(bus.num_dispatching);
        ret_req_s  = cnt_t'(bus.num_retiring);
        disp_s     = (disp_req_s > spots_s) ? spots_s : disp_req_s;
        ret_s      = (ret_req_s > valid_s) ? valid_s : ret_req_s;
    end

    // Bus outputs: counts and the N oldest entries starting at head.
    always_comb begin
        bus.rob_spots         = NUM_SCALAR_BITS'(spots_s);
        bus.rob_outputs_valid = NUM_SCALAR_BITS'(valid_s);
        for (int i = 0; i < N; i++) begin
            bus.rob_outputs[i] = entries_r[ptr_add(head_r, cnt_t'(i))];
        end
    end

    // Head, tail and count update; reset outranks flush, flush outranks traffic.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (bus.flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= ptr_add(head_r, ret_s);
            tail_r  <= ptr_add(tail_r, disp_s);
            count_r <= count_r + disp_s - ret_s;
        end
    end

    // Entry writes for the accepted dispatch lanes; contents are never cleared.
    always_ff @(posedge clock) begin
        if (!reset && !bus.flush) begin
            for (int i = 0; i < N; i++) begin
                if (cnt_t'(i) < disp_s) begin
                    entries_r[ptr_add(tail_r, cnt_t'(i))] <= bus.rob_inputs[i];
                end
            end
        end
    end

    rob_sva #(
        .N        (N),
        .ROB_SZ   (ROB_SZ),
        .CNT_W    (CNT_W),
        .SCALAR_W (NUM_SCALAR_BITS)
    ) u_rob_sva (
        .clock             (clock),
        .reset             (reset),
        .num_retiring      (bus.num_retiring),
        .rob_outputs_valid (bus.rob_outputs_valid),
        .rob_spots         (bus.rob_spots),
        .count             (count_r)
    );

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob with N=3, ROB_SZ=8: a table of per-cycle inputs and
// hand-computed expected outputs, followed by a hand-written sequence that
// fills the buffer and then dispatches and retires together while full.
module tb_rob;
    import rob_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    rob_if #(.N(3)) bus ();

    rob #(.N(3), .ROB_SZ(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        fl;
        int          nd;
        int          nr;
        logic [31:0] pcb;
        int          spots;
        int          valid;
        logic [31:0] o0;
        logic [31:0] o1;
        logic [31:0] o2;
    } vec_t;

    vec_t tbl [21];

    task automatic step(input logic rst, input logic fl, input int nd, input int nr,
                        input logic [31:0] pcb);
        @(negedge clock);
        reset               = rst;
        bus.flush           = fl;
        bus.num_dispatching = NUM_SCALAR_BITS'(nd);
        bus.num_retiring    = NUM_SCALAR_BITS'(nr);
        for (int i = 0; i < 3; i++) begin
            bus.rob_inputs[i] = '{t_new: 6'(i + 1), t_old: 6'(i), arch_dest: 5'(i),
                                  pc: pcb + 32'(i), halt: 1'b0, illegal: 1'b0};
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input int sp, input int vl,
                             input logic [31:0] o0, input logic [31:0] o1,
                             input logic [31:0] o2);
        logic [31:0] exp_pc [3];
        exp_pc[0] = o0;
        exp_pc[1] = o1;
        exp_pc[2] = o2;
        checks++;
        if (int'(bus.rob_spots) != sp) begin
            failures++;
            $display("FAIL %s rob_spots got %0d want %0d", tag, bus.rob_spots, sp);
        end
        checks++;
        if (int'(bus.rob_outputs_valid) != vl) begin
            failures++;
            $display("FAIL %s rob_outputs_valid got %0d want %0d", tag,
                     bus.rob_outputs_valid, vl);
        end
        for (int i = 0; i < vl; i++) begin
            checks++;
            if (bus.rob_outputs[i].pc !== exp_pc[i]) begin
                failures++;
                $display("FAIL %s lane%0d pc got %h want %h", tag, i,
                         bus.rob_outputs[i].pc, exp_pc[i]);
            end
        end
    endtask

    initial begin
        checks              = 0;
        failures            = 0;
        reset               = 1'b1;
        bus.flush           = 1'b0;
        bus.num_dispatching = '0;
        bus.num_retiring    = '0;
        for (int i = 0; i < 3; i++) bus.rob_inputs[i] = '0;

        //          rst   fl    nd nr pc_base  spots valid lane0  lane1  lane2
        tbl[0]  = '{1'b1, 1'b0, 0, 0, 32'h00, 3, 0, 32'h00, 32'h00, 32'h00};
        tbl[1]  = '{1'b0, 1'b0, 3, 0, 32'h10, 3, 3, 32'h10, 32'h11, 32'h12};
        tbl[2]  = '{1'b0, 1'b0, 3, 0, 32'h20, 2, 3, 32'h10, 32'h11, 32'h12};
        tbl[3]  = '{1'b0, 1'b0, 3, 0, 32'h30, 0, 3, 32'h10, 32'h11, 32'h12};
        tbl[4]  = '{1'b0, 1'b0, 3, 0, 32'h40, 0, 3, 32'h10, 32'h11, 32'h12};
        tbl[5]  = '{1'b0, 1'b0, 0, 3, 32'h00, 3, 3, 32'h20, 32'h21, 32'h22};
        tbl[6]  = '{1'b0, 1'b0, 3, 0, 32'hA0, 0, 3, 32'h20, 32'h21, 32'h22};
        tbl[7]  = '{1'b0, 1'b0, 0, 3, 32'h00, 3, 3, 32'h30, 32'h31, 32'hA0};
        tbl[8]  = '{1'b0, 1'b0, 0, 2, 32'h00, 3, 3, 32'hA0, 32'hA1, 32'hA2};
        tbl[9]  = '{1'b0, 1'b0, 2, 0, 32'hB0, 3, 3, 32'hA0, 32'hA1, 32'hA2};
        tbl[10] = '{1'b0, 1'b0, 2, 2, 32'hC0, 3, 3, 32'hA2, 32'hB0, 32'hB1};
        tbl[11] = '{1'b0, 1'b0, 0, 3, 32'h00, 3, 2, 32'hC0, 32'hC1, 32'h00};
        tbl[12] = '{1'b0, 1'b0, 0, 1, 32'h00, 3, 1, 32'hC1, 32'h00, 32'h00};
        tbl[13] = '{1'b0, 1'b0, 0, 3, 32'h00, 3, 0, 32'h00, 32'h00, 32'h00};
        tbl[14] = '{1'b0, 1'b0, 0, 2, 32'h00, 3, 0, 32'h00, 32'h00, 32'h00};
        tbl[15] = '{1'b0, 1'b0, 3, 0, 32'hD0, 3, 3, 32'hD0, 32'hD1, 32'hD2};
        tbl[16] = '{1'b0, 1'b0, 3, 0, 32'hE0, 2, 3, 32'hD0, 32'hD1, 32'hD2};
        tbl[17] = '{1'b0, 1'b1, 3, 1, 32'hF0, 3, 0, 32'h00, 32'h00, 32'h00};
        tbl[18] = '{1'b0, 1'b0, 3, 0, 32'h60, 3, 3, 32'h60, 32'h61, 32'h62};
        tbl[19] = '{1'b1, 1'b1, 3, 1, 32'h70, 3, 0, 32'h00, 32'h00, 32'h00};
        tbl[20] = '{1'b0, 1'b0, 1, 0, 32'h80, 3, 1, 32'h80, 32'h00, 32'h00};

        for (int k = 0; k < 21; k++) begin
            step(tbl[k].rst, tbl[k].fl, tbl[k].nd, tbl[k].nr, tbl[k].pcb);
            check_out($sformatf("vec%0d", k), tbl[k].spots, tbl[k].valid,
                      tbl[k].o0, tbl[k].o1, tbl[k].o2);
        end

        // From head=0, count=1 (0x80 at entry 0): fill to full, where the
        // last dispatch is clamped to a single lane.
        step(1'b0, 1'b0, 3, 0, 32'h90);
        check_out("fill_a", 3, 3, 32'h80, 32'h90, 32'h91);
        step(1'b0, 1'b0, 3, 0, 32'hB8);
        check_out("fill_b", 1, 3, 32'h80, 32'h90, 32'h91);
        step(1'b0, 1'b0, 3, 0, 32'hC8);
        check_out("fill_full", 0, 3, 32'h80, 32'h90, 32'h91);
        // Dispatch and retire together while full: spots were 0, so only the
        // retire takes effect and count drops to 5.
        step(1'b0, 1'b0, 3, 3, 32'hD8);
        check_out("full_disp_ret", 3, 3, 32'h92, 32'hB8, 32'hB9);
        step(1'b0, 1'b0, 0, 3, 32'h00);
        check_out("drain_tail", 3, 2, 32'hBA, 32'hC8, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
